// File: rtl/cnn_acc_requant_24s.sv
`default_nettype none
// ============================================================================
// Module   : cnn_acc_requant_24s
// Purpose  : Sums ACC_LEN signed products plus a scaled bias, then rounds,
//            shifts and saturates the sum to a signed OUT_WIDTH result.
// Options  : define CNN_ACC_RELU_EN to zero negative results (ReLU).
// Revision : 1.0 - initial release
// ============================================================================
module cnn_acc_requant_24s #(
    parameter int ACC_LEN    = 9,
    parameter int PROD_WIDTH = 24,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_din,
    input  logic                  prod_vld,
    output logic                  prod_rdy,
    input  logic [OUT_WIDTH-1:0]  bias_din,
    output logic [OUT_WIDTH-1:0]  acc_dout,
    output logic                  acc_vld,
    input  logic                  acc_rdy,
    output logic                  sat_flag
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] c_len = CNT_W'(ACC_LEN);
    localparam logic [ACC_WIDTH:0] c_half =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] c_max =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] c_min =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                       r_state;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]             r_count;
    logic [OUT_WIDTH-1:0]         r_dout;
    logic                         r_vld;
    logic                         r_sat;

    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_bias_shl;
    logic [CNT_W-1:0]             w_count_nxt;
    logic                         w_accept;
    logic signed [ACC_WIDTH:0]    w_rnd;
    logic signed [ACC_WIDTH:0]    w_shr;
    logic                         w_pos_clip;
    logic                         w_neg_clip;
    logic [OUT_WIDTH-1:0]         w_res;
    logic                         w_sat;

    assign prod_rdy    = (r_state == IDLE) || (r_state == ACCUM);
    assign w_accept    = prod_vld & prod_rdy;
    assign w_prod_ext  = {{(ACC_WIDTH - PROD_WIDTH){prod_din[PROD_WIDTH-1]}}, prod_din};
    assign w_bias_shl  = {{(ACC_WIDTH - OUT_WIDTH){bias_din[OUT_WIDTH-1]}}, bias_din} <<< FRAC_SHIFT;
    assign w_count_nxt = r_count + CNT_W'(1);

    // One guard bit so the rounding offset can never wrap a near-full accumulator.
    assign w_rnd      = {r_acc[ACC_WIDTH-1], r_acc} + c_half;
    assign w_shr      = w_rnd >>> FRAC_SHIFT;
    assign w_pos_clip = (w_shr > c_max);
    assign w_neg_clip = (w_shr < c_min);

    always_comb begin
        w_res = w_shr[OUT_WIDTH-1:0];
        w_sat = w_pos_clip | w_neg_clip;
        if (w_pos_clip) begin
            w_res = c_max[OUT_WIDTH-1:0];
        end else if (w_neg_clip) begin
            w_res = c_min[OUT_WIDTH-1:0];
        end
`ifdef CNN_ACC_RELU_EN
        if (w_res[OUT_WIDTH-1]) begin
            w_res = '0;
            w_sat = 1'b0;
        end
`endif
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_vld   <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc   <= w_bias_shl + w_prod_ext;
                        r_count <= CNT_W'(1);
                        r_state <= (ACC_LEN == 1) ? ROUND : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= r_acc + w_prod_ext;
                        r_count <= w_count_nxt;
                        if (w_count_nxt == c_len) begin
                            r_state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    r_dout  <= w_res;
                    r_sat   <= w_sat;
                    r_vld   <= 1'b1;
                    r_state <= OUT;
                end
                OUT: begin
                    if (acc_rdy) begin
                        r_vld   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign acc_dout = r_dout;
    assign acc_vld  = r_vld;
    assign sat_flag = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_cnn_acc_requant_24s.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_acc_requant_24s
// Purpose  : Directed and randomized windows against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_acc_requant_24s;

    localparam int ACC_LEN = 9;
    localparam int PW      = 24;
    localparam int OW      = 16;
    localparam int FS      = 8;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst;
    logic signed [PW-1:0] prod_din;
    logic                 prod_vld;
    logic                 prod_rdy;
    logic signed [OW-1:0] bias_din;
    logic signed [OW-1:0] acc_dout;
    logic                 acc_vld;
    logic                 acc_rdy;
    logic                 sat_flag;

    int checks   = 0;
    int failures = 0;
    logic signed [PW-1:0] p [ACC_LEN];

    cnn_acc_requant_24s dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .prod_din (prod_din),
        .prod_vld (prod_vld),
        .prod_rdy (prod_rdy),
        .bias_din (bias_din),
        .acc_dout (acc_dout),
        .acc_vld  (acc_vld),
        .acc_rdy  (acc_rdy),
        .sat_flag (sat_flag)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Reference: exact integer sum, floor(x/2^FS + 1/2), then clamp.
    function automatic void model(input int bias, output longint r, output bit sat);
        longint s;
        s = longint'(bias) * (longint'(1) <<< FS);
        for (int i = 0; i < ACC_LEN; i++) s += longint'(p[i]);
        r   = (s + (longint'(1) <<< (FS - 1))) >>> FS;
        sat = 1'b0;
        if (r > 32767) begin
            r = 32767; sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768; sat = 1'b1;
        end
`ifdef CNN_ACC_RELU_EN
        if (r < 0) begin
            r = 0; sat = 1'b0;
        end
`endif
    endfunction

    task automatic run_window(input logic signed [OW-1:0] bias, input int stall,
                              input int max_gap, input string tag);
        longint     er;
        bit         es;
        logic [31:0] t;
        model(int'(bias), er, es);
        for (int i = 0; i < ACC_LEN; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                prod_vld = 1'b0;
                t = $urandom; prod_din = t[PW-1:0];
                acc_rdy  = t[31];
                tick();
                check({tag, ":gap_vld"}, acc_vld, 0);
            end
            check({tag, ":rdy_in"}, prod_rdy, 1);
            t = $urandom;
            prod_vld = 1'b1;
            prod_din = p[i];
            bias_din = (i == 0) ? bias : t[OW-1:0];
            acc_rdy  = t[31];
            tick();
        end
        // ROUND cycle: inputs here must be ignored.
        t = $urandom;
        prod_vld = 1'b1;
        prod_din = t[PW-1:0];
        acc_rdy  = t[30];
        check({tag, ":round_vld"}, acc_vld, 0);
        check({tag, ":round_rdy"}, prod_rdy, 0);
        tick();
        check({tag, ":out_vld"}, acc_vld, 1);
        check({tag, ":dout"}, acc_dout, er);
        check({tag, ":sat"}, sat_flag, es);
        check({tag, ":out_rdy"}, prod_rdy, 0);
        for (int s = 0; s < stall; s++) begin
            acc_rdy  = 1'b0;
            prod_vld = 1'b1;
            tick();
            check({tag, ":stall_vld"}, acc_vld, 1);
            check({tag, ":stall_dout"}, acc_dout, er);
            check({tag, ":stall_sat"}, sat_flag, es);
            check({tag, ":stall_rdy"}, prod_rdy, 0);
        end
        prod_vld = 1'b0;
        acc_rdy  = 1'b1;
        tick();
        check({tag, ":post_vld"}, acc_vld, 0);
        check({tag, ":post_rdy"}, prod_rdy, 1);
    endtask

    initial begin
        logic [31:0] t;
        int          v;
        ap_rst   = 1'b1;
        prod_din = '0;
        prod_vld = 1'b0;
        bias_din = '0;
        acc_rdy  = 1'b0;
        repeat (3) tick();
        check("rst_vld", acc_vld, 0);
        check("rst_dout", acc_dout, 0);
        check("rst_sat", sat_flag, 0);
        ap_rst = 1'b0;
        check("rst_rdy", prod_rdy, 1);

        // Nine products of 256, no bias, no gaps: result 9.
        for (int i = 0; i < ACC_LEN; i++) p[i] = 24'sd256;
        run_window(16'sd0, 0, 0, "ones");

        for (int i = 0; i < ACC_LEN; i++) p[i] = '0;
        p[0] = 24'sd200; p[3] = 24'sd184;
        run_window(16'sd0, 0, 2, "pos384");
        p[0] = -24'sd400; p[3] = 24'sd16;
        run_window(16'sd0, 0, 2, "neg384");

        for (int i = 0; i < ACC_LEN; i++) p[i] = 24'sh7FFFFF;
        run_window(16'sd0, 0, 1, "satpos");
        for (int i = 0; i < ACC_LEN; i++) p[i] = 24'sh800000;
        run_window(16'sd0, 0, 1, "satneg");

        for (int i = 0; i < ACC_LEN; i++) p[i] = '0;
        p[8] = 24'sd512;
        run_window(16'sd5, 0, 1, "bias5");

        for (int i = 0; i < ACC_LEN; i++) p[i] = 24'sd300;
        run_window(-16'sd7, 4, 0, "stall4");

        // Abort a window after four accepts; reset wins over the handshake.
        for (int i = 0; i < 4; i++) begin
            prod_vld = 1'b1;
            prod_din = 24'sh100000;
            bias_din = 16'sd1000;
            tick();
        end
        ap_rst   = 1'b1;
        acc_rdy  = 1'b1;
        tick();
        check("abort_vld", acc_vld, 0);
        check("abort_dout", acc_dout, 0);
        check("abort_sat", sat_flag, 0);
        ap_rst   = 1'b0;
        prod_vld = 1'b0;
        check("abort_rdy", prod_rdy, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_out", acc_vld, 0);
        end
        for (int i = 0; i < ACC_LEN; i++) p[i] = 24'sd256;
        run_window(16'sd0, 0, 0, "fresh");

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < ACC_LEN; i++) begin
                t = $urandom;
                if (n[0]) begin
                    p[i] = t[PW-1:0];
                end else begin
                    v    = int'($urandom_range(65535, 0)) - 32768;
                    p[i] = v[PW-1:0];
                end
            end
            t = $urandom;
            run_window(t[OW-1:0], int'($urandom_range(3, 0)), 2, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/cnn_acc_requant_24s.md
CNN_ACC_REQUANT_24S -- requirements
Module: cnn_acc_requant_24s

Interface
REQ-001 SHALL have parameter ACC_LEN, default 9, the number of products summed per output (must be 1..255).
REQ-002 SHALL have parameter PROD_WIDTH, default 24, the signed product width from the upstream 10s x 14s multiplier.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, the signed accumulator width.
REQ-004 SHALL have parameter OUT_WIDTH, default 16, the signed result width.
REQ-005 SHALL have parameter FRAC_SHIFT, default 8, the right shift applied at requantization (must be at least 1).
REQ-006 SHALL have port ap_clk, input, 1 bit, the sole clock; all logic rising-edge.
REQ-007 SHALL have port ap_rst, input, 1 bit, the reset: synchronous, active-high.
REQ-008 SHALL have port prod_din, input, PROD_WIDTH bits, the signed product.
REQ-009 SHALL have port prod_vld, input, 1 bit, marking prod_din valid.
REQ-010 SHALL have port prod_rdy, output, 1 bit, indicating the block can accept a product.
REQ-011 SHALL have port bias_din, input, OUT_WIDTH bits, the signed bias, sampled with the first product of each window.
REQ-012 SHALL have port acc_dout, output, OUT_WIDTH bits, the signed requantized result.
REQ-013 SHALL have port acc_vld, output, 1 bit, marking acc_dout valid.
REQ-014 SHALL have port acc_rdy, input, 1 bit, the downstream ready.
REQ-015 SHALL have port sat_flag, output, 1 bit, set when acc_dout was clamped; valid while acc_vld=1.

Function
REQ-016 SHALL implement an FSM with states IDLE, ACCUM, ROUND and OUT.
REQ-017 SHALL accept a product only on a cycle with prod_vld=1 and prod_rdy=1.
REQ-018 SHALL drive prod_rdy=1 in IDLE and ACCUM, and prod_rdy=0 in ROUND and OUT.
REQ-019 SHALL, on an accept in IDLE, load acc = (sign-extended bias_din << FRAC_SHIFT) + sign-extended prod_din, set count=1, and go to ACCUM (or to ROUND if ACC_LEN=1).
REQ-020 SHALL, on an accept in ACCUM, add the sign-extended prod_din to acc and increment count; it SHALL go to ROUND when count reaches ACC_LEN.
REQ-021 SHALL hold acc and count unchanged in ACCUM on cycles without an accept; gaps of any length SHALL be permitted.
REQ-022 SHALL, in ROUND, compute r = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (arithmetic shift, round-half-up), clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], register acc_dout and sat_flag, and go to OUT; ROUND SHALL last exactly one cycle.
REQ-023 SHALL drive acc_vld=1 in OUT, with acc_dout and sat_flag held stable until acc_rdy=1.
REQ-024 SHALL go to IDLE on the cycle after OUT with acc_rdy=1.
REQ-025 SHALL give a latency of 2 cycles from the accept of the ACC_LEN-th product to acc_vld=1.
REQ-026 SHALL NOT let accumulator overflow wrap silently; intermediate sums SHALL be computed at ACC_WIDTH with sign extension.
REQ-027 SHALL ignore acc_rdy outside OUT and ignore prod_vld while prod_rdy=0.

Reset
REQ-028 SHALL, on ap_rst=1 at a rising edge, force state=IDLE, acc=0, count=0, acc_dout=0, acc_vld=0 and sat_flag=0.
REQ-029 SHALL let ap_rst override any simultaneous handshake.
REQ-030 SHALL abandon a partial window when reset is asserted mid-window, producing no output for it.
REQ-031 SHALL give prod_rdy=1 on the first cycle after reset deasserts.

Configuration
REQ-032 SHALL, when CNN_ACC_RELU_EN is defined, replace a negative clamped result with 0 before registering, setting sat_flag only for positive clamping.
REQ-033 SHALL, when CNN_ACC_RELU_EN is undefined, output negative results unchanged (subject only to clamping).

Verification
REQ-034 SHALL cover: 9 products of 256 with bias 0, acc_rdy=1 -> acc_dout=9, sat_flag=0, acc_vld exactly 2 cycles after the 9th accept.
REQ-035 SHALL cover: products summing to 384 with bias 0 -> acc_dout=2; products summing to -384 -> acc_dout=-1.
REQ-036 SHALL cover: 9 products of 0x7FFFFF -> acc_dout=32767, sat_flag=1; 9 products of 0x800000 -> acc_dout=-32768, sat_flag=1 (with CNN_ACC_RELU_EN defined: acc_dout=0, sat_flag=0).
REQ-037 SHALL cover: bias 5 with products summing to 512 -> acc_dout=7.
REQ-038 SHALL cover: acc_rdy=0 for 4 cycles in OUT -> acc_dout stable, prod_rdy=0 throughout, a single transfer once acc_rdy=1.
REQ-039 SHALL cover: reset after 4 products, then a fresh 9-product window of 256 -> acc_dout=9, with no residue from the aborted window.
